// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: word width, frame constants,
// FSM state encoding and the checksum helper.
package boot_loader_ctrl_pkg;

  localparam int WORD_W    = 32;
  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Payload checksum is a plain modulo-256 byte sum.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the completed word is
// presented combinationally alongside the fourth byte.
module word_packer
  import boot_loader_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        data,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [1:0]          lane_r;
  logic [WORD_W-9:0]   low_r;

  // Lane counter and the three lower byte lanes of the word in progress.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_r <= 2'd0;
      low_r  <= '0;
    end else if (push) begin
      lane_r <= lane_r + 2'd1;
      case (lane_r)
        2'd0:    low_r[7:0]   <= data;
        2'd1:    low_r[15:8]  <= data;
        2'd2:    low_r[23:16] <= data;
        default: low_r        <= low_r;
      endcase
    end else begin
      lane_r <= lane_r;
      low_r  <= low_r;
    end
  end

  assign word_done = push && (lane_r == 2'd3);
  assign word      = {data, low_r};

endmodule

// File: rtl/boot_loader_ctrl.sv
// Program-load controller: frames UART bytes as length/payload/checksum, writes
// instruction memory and holds the CPU until a verified image is in place.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int XLEN    = WORD_W,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]   DEPTH_MAX = 17'(DEPTH);

  state_t              state_r, state_s;
  logic [7:0]          len_lo_r;
  logic [15:0]         len_r, len_s;
  logic [ADDR_W-1:0]   index_r;
  logic [CSUM_W-1:0]   csum_r;
  logic [15:0]         words_loaded_r;
  logic [TW-1:0]       idle_r;
  logic                timed_s, timeout_s, start_s, push_s, word_done_s, last_word_s;
  logic [WORD_W-1:0]   word_s;
  logic                imem_we_r, cpu_hold_r, load_done_r, load_err_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic [XLEN-1:0]     imem_wdata_r;

  assign len_s       = {byte_data, len_lo_r};
  assign timed_s     = (state_r == ST_LEN_HI) || (state_r == ST_DATA) || (state_r == ST_CSUM);
  assign timeout_s   = timed_s && !byte_valid && (idle_r == IDLE_LAST);
  assign start_s     = byte_valid && (state_r == ST_LEN_HI);
  assign push_s      = byte_valid && (state_r == ST_DATA);
  assign last_word_s = word_done_s && (words_loaded_r == len_r - 16'd1);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_s),
    .push      (push_s),
    .data      (byte_data),
    .word_done (word_done_s),
    .word      (word_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_LEN_LO;
    else     state_r <= state_s;
  end

  // Next-state logic; a byte arriving on the timeout cycle wins over the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LEN_LO: begin
        if (byte_valid) state_s = ST_LEN_HI;
        else            state_s = state_r;
      end
      ST_LEN_HI: begin
        if (byte_valid) begin
          if ({1'b0, len_s} > DEPTH_MAX) state_s = ST_ERROR;
          else if (len_s == 16'd0)       state_s = ST_CSUM;
          else                           state_s = ST_DATA;
        end else if (timeout_s) state_s = ST_ERROR;
        else                    state_s = state_r;
      end
      ST_DATA: begin
        if (last_word_s)    state_s = ST_CSUM;
        else if (timeout_s) state_s = ST_ERROR;
        else                state_s = state_r;
      end
      ST_CSUM: begin
        if (byte_valid)     state_s = (byte_data == csum_r) ? ST_DONE : ST_ERROR;
        else if (timeout_s) state_s = ST_ERROR;
        else                state_s = state_r;
      end
      ST_DONE: state_s = ST_RUN;
      ST_RUN, ST_ERROR: begin
        if (boot_req) state_s = ST_LEN_LO;
        else          state_s = state_r;
      end
      default: state_s = ST_LEN_LO;
    endcase
  end

  // Length latch, write index, checksum accumulator and word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_r       <= 8'd0;
      len_r          <= 16'd0;
      index_r        <= '0;
      csum_r         <= '0;
      words_loaded_r <= 16'd0;
    end else if (start_s) begin
      len_r          <= len_s;
      index_r        <= '0;
      csum_r         <= '0;
      words_loaded_r <= 16'd0;
    end else if (push_s) begin
      csum_r <= csum_add(csum_r, byte_data);
      if (word_done_s) begin
        index_r        <= index_r + ADDR_W'(1);
        words_loaded_r <= words_loaded_r + 16'd1;
      end
    end else if (byte_valid && (state_r == ST_LEN_LO)) begin
      len_lo_r <= byte_data;
    end
  end

  // Inter-byte idle counter, live only while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst || byte_valid || !timed_s) idle_r <= '0;
    else if (idle_r != IDLE_LAST)      idle_r <= idle_r + TW'(1);
    else                               idle_r <= idle_r;
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
      cpu_hold_r   <= 1'b1;
      load_done_r  <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      imem_we_r <= word_done_s;
      if (word_done_s) begin
        imem_addr_r  <= index_r;
        imem_wdata_r <= word_s;
      end
      cpu_hold_r  <= (state_s != ST_RUN);
      load_done_r <= (state_s == ST_DONE);
      load_err_r  <= (state_s == ST_ERROR);
    end
  end

  assign imem_we      = imem_we_r;
  assign imem_addr    = imem_addr_r;
  assign imem_wdata   = imem_wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign load_done    = load_done_r;
  assign load_err     = load_err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed frame table, multi-cycle
// corner sequences and random frames against a frame-level reference model.
module tb_boot_loader_ctrl;
  import boot_loader_ctrl_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst, byte_valid, boot_req;
  logic [7:0]        byte_data;
  logic              imem_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [15:0]       words_loaded;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          adj;
    bit          exp_err;
    int          exp_loaded;
  } vec_t;

  wr_t         wr_q[$];
  int          done_cnt;
  logic [31:0] fw[0:31];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .boot_req     (boot_req),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Capture memory writes and load_done pulses away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (imem_we === 1'b1) wr_q.push_back('{imem_addr, imem_wdata});
      if (load_done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_boot_req();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    wr_q.delete();
    done_cnt = 0;
  endtask

  function automatic logic [7:0] csum_of(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) s += int'(fw[i][8*k +: 8]);
    return 8'(s);
  endfunction

  task automatic send_frame(input int n, input int adj, input int gap);
    logic [15:0] nn;
    nn = 16'(n);
    for (int h = 0; h < HDR_BYTES; h++) begin
      idle(int'($urandom_range(gap, 0)));
      send_byte(nn[8*h +: 8]);
    end
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          idle(int'($urandom_range(gap, 0)));
          send_byte(fw[i][8*k +: 8]);
        end
      idle(int'($urandom_range(gap, 0)));
      send_byte(8'(int'(csum_of(n)) + adj));
    end
  endtask

  task automatic check_frame(input string nm, input bit exp_err, input int exp_n);
    idle(3);
    check({nm, " load_err"}, 32'(load_err), 32'(exp_err));
    check({nm, " cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({nm, " load_done"}, 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
    check({nm, " words_loaded"}, 32'(words_loaded), 32'(exp_n));
    check({nm, " n_writes"}, 32'(wr_q.size()), 32'(exp_n));
    for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
      check({nm, " addr"}, 32'(wr_q[i].addr), 32'(i));
      check({nm, " data"}, wr_q[i].data, fw[i]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    boot_req   = 1'b0;
    byte_data  = 8'h00;
    done_cnt   = 0;
    idle(3);
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst imem_we", 32'(imem_we), 32'd0);
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst imem_wdata", imem_wdata, 32'd0);
    check("rst load_done", 32'(load_done), 32'd0);
    check("rst load_err", 32'(load_err), 32'd0);
    check("rst words_loaded", 32'(words_loaded), 32'd0);
    rst = 1'b0;

    vecs[0] = '{2,         32'h00500093, 32'h00100113, 0,   1'b0, 2};
    vecs[1] = '{2,         32'h00500093, 32'h00100113, 1,   1'b1, 2};
    vecs[2] = '{0,         32'h0,        32'h0,        0,   1'b0, 0};
    vecs[3] = '{DEPTH + 1, 32'h11111111, 32'h22222222, 0,   1'b1, 0};
    vecs[4] = '{DEPTH,     32'hA5A50000, 32'h0000F00F, 0,   1'b0, DEPTH};
    vecs[5] = '{1,         32'hDEADBEEF, 32'h0,        128, 1'b1, 1};

    for (int v = 0; v < 6; v++) begin
      pulse_boot_req();
      check("req load_err", 32'(load_err), 32'd0);
      check("req cpu_hold", 32'(cpu_hold), 32'd1);
      fw[0] = vecs[v].w0;
      fw[1] = vecs[v].w1;
      for (int i = 2; i < 32; i++) fw[i] = vecs[v].w0 + 32'(i);
      send_frame(vecs[v].n, vecs[v].adj, v % 3);
      if (vecs[v].n > DEPTH) check("oversize err", 32'(load_err), 32'd1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_loaded);
    end

    // Frame stalls mid-word: error exactly TIMEOUT cycles after the last byte.
    pulse_boot_req();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TIMEOUT - 1);
    check("timeout early", 32'(load_err), 32'd0);
    idle(1);
    check("timeout err", 32'(load_err), 32'd1);
    check("timeout hold", 32'(cpu_hold), 32'd1);
    check("timeout writes", 32'(wr_q.size()), 32'd0);

    // Reset in the middle of an N=3 frame, then a fresh N=1 frame.
    pulse_boot_req();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst words_loaded", 32'(words_loaded), 32'd0);
    check("midrst imem_wdata", imem_wdata, 32'd0);
    check("midrst load_err", 32'(load_err), 32'd0);
    wr_q.delete();
    done_cnt = 0;
    fw[0] = 32'h12345678;
    send_frame(1, 0, 0);
    check_frame("after_rst", 1'b0, 1);

    // boot_req and a byte together in RUN: the byte must be dropped.
    check("run hold", 32'(cpu_hold), 32'd0);
    boot_req   = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h05;
    @(negedge clk);
    boot_req   = 1'b0;
    byte_valid = 1'b0;
    check("breq hold", 32'(cpu_hold), 32'd1);
    wr_q.delete();
    done_cnt = 0;
    fw[0] = 32'hCAFEF00D;
    send_frame(1, 0, 0);
    check_frame("breq_frame", 1'b0, 1);

    // Random frames against the frame-level model.
    for (int r = 0; r < 25; r++) begin
      int  n, adj;
      bit  bad, exp_err;
      pulse_boot_req();
      n   = int'($urandom_range(DEPTH + 2, 0));
      for (int i = 0; i < 32; i++) fw[i] = $urandom;
      bad = ($urandom_range(3, 0) == 0);
      adj = bad ? int'($urandom_range(255, 1)) : 0;
      send_frame(n, adj, 2);
      exp_err = (n > DEPTH) || bad;
      check_frame($sformatf("rand%0d", r), exp_err, (n > DEPTH) ? 0 : n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Program-load controller for the instruction memory. It takes the byte stream from the UART receiver and frames it as length, payload and checksum. It packs the payload bytes into 32-bit little-endian words and drives the write side of the instruction BRAM. It holds the CPU pipeline stalled until a complete, checksum-verified image has been written, then releases it into RUN, and re-enters loading on request.

## Interface
Parameters:
- XLEN, 32: instruction word width; fixed at 32.
- ADDR_W, 16: instruction-memory word-address width.
- DEPTH, 4096: instruction-memory capacity in words; a length field above DEPTH is an error.
- TIMEOUT, 50000: maximum idle cycles allowed between bytes once a frame has started.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset; synchronous, active-high.
- byte_valid  in  1  one-cycle strobe from the UART receiver: a byte is available.
- byte_data  in  8  received byte; sampled only when byte_valid=1.
- boot_req  in  1  request to reload; honoured only in RUN or ERROR.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  XLEN  packed instruction word.
- cpu_hold  out  1  stalls and holds the pipeline; deasserted only in RUN.
- load_done  out  1  one-cycle pulse on entry to RUN.
- load_err  out  1  level; high while in ERROR.
- words_loaded  out  16  count of words written in the current or last load.

## Operation
Frame format, in byte order:
- LEN_LO, LEN_HI: 16-bit word count N.
- 4·N payload bytes, little-endian per word.
- One checksum byte: the sum mod 256 of all payload bytes.

State machine:
- LEN_LO: on byte_valid, latch N[7:0] → LEN_HI.
- LEN_HI: on byte_valid, latch N[15:8]. Then:
  - if N > DEPTH → ERROR;
  - if N = 0 → CSUM;
  - otherwise → DATA.
  - Clear the word index, checksum accumulator and words_loaded.
- DATA:
  - Each byte goes to byte lane k = 0..3 of the word being packed and is added to the checksum accumulator.
  - When lane 3 is filled: imem_we=1, imem_addr=index, imem_wdata=packed word, then index++ and words_loaded++.
  - After word N-1 is written → CSUM.
- CSUM: on byte_valid, compare the byte with the accumulator. Equal → DONE; unequal → ERROR.
- DONE: one cycle; load_done=1 → RUN.
- RUN: cpu_hold=0. boot_req → LEN_LO.
- ERROR: cpu_hold=1, load_err=1. boot_req → LEN_LO, which clears load_err.

Timeout:
- An idle counter runs in LEN_HI, DATA and CSUM and clears on every byte_valid.
- When it reaches TIMEOUT-1 → ERROR.
- LEN_LO waits forever.

Boundary rules:
- Words are written before the checksum is verified. A bad image therefore sits in memory but is never executed, because cpu_hold stays at 1.
- boot_req in any loading state (LEN_LO, LEN_HI, DATA, CSUM) is ignored.
- boot_req together with byte_valid in RUN or ERROR: boot_req is taken and the byte is discarded.
- byte_valid in DONE, RUN or ERROR is ignored.
- imem_addr wraps naturally at 2^ADDR_W. This cannot occur in practice because N ≤ DEPTH.

## Timing
- Reset values:
  - state = LEN_LO;
  - cpu_hold = 1;
  - imem_we = 0, imem_addr = 0, imem_wdata = 0;
  - load_done = 0, load_err = 0;
  - words_loaded = 0;
  - internal counters and accumulator = 0.
- Applying rst in the middle of a frame abandons the frame; the next byte is treated as LEN_LO.
- All outputs are registered.
- imem_we is asserted in the cycle after the 4th byte of a word is accepted.
- Back-to-back byte_valid pulses, one per cycle, are supported without loss.
- load_done rises one cycle after the checksum byte is accepted. cpu_hold falls one cycle after that, together with entry to RUN.
- ERROR is entered in the cycle after the offending byte, or on the cycle the timeout expires.

## Structure
- Take XLEN from the shared config include.
- Put the state encodings and the frame constants (header length, checksum width) in a shared boot_defs include, so the UART host tool documentation and the testbench use the same values.
- Implement the byte-lane packing, lane counter and word register as one sub-module, word_packer.
- The top of this block holds the FSM, the timeout counter and the checksum accumulator.

## Test plan
- Send N=2, words 0x00500093 and 0x00100113, correct checksum → two imem_we pulses at addresses 0 and 1 with those data; load_done pulses once; cpu_hold falls; words_loaded=2.
- Same frame with the checksum byte incremented by 1 → both words written, then load_err=1 and cpu_hold stays 1; a boot_req then returns the FSM to LEN_LO with load_err=0.
- Send N=0 then checksum 0x00 → no writes, then RUN. Send N=DEPTH+1 → ERROR right after LEN_HI, with no writes.
- Send N=1, stop after 2 payload bytes → ERROR exactly TIMEOUT cycles after the last byte, with no imem_we.
- Assert rst after 5 payload bytes of an N=3 frame, then send a fresh N=1 frame → the fresh frame loads correctly at address 0.
- In RUN, drive boot_req and byte_valid in the same cycle → cpu_hold rises, the byte is not counted as LEN_LO, and the next byte is taken as LEN_LO.
